axis_s_rx: RTL

// AXI4-Stream slave receiver; sits directly downstream of the AXI-Stream master stage and consumes its tdata/tvalid/tlast.

---
 rtl/axis_s_rx_pkg.sv | 14 +
 rtl/axis_s_fifo.sv | 53 +++++
 rtl/axis_s_rx.sv | 131 +++++++++++++
 3 files changed

// File: rtl/axis_s_rx_pkg.sv
// Shared types and constants for the AXI4-Stream slave receiver.
package axis_s_rx_pkg;

   localparam int AXIS_DATA_W = 8;
   localparam int PKT_CNT_W   = 16;

   typedef enum logic {IDLE = 1'b0, RECV = 1'b1} rx_state_e;

   typedef struct packed {
      logic                   last;
      logic [AXIS_DATA_W-1:0] data;
   } beat_t;

endpackage

// File: rtl/axis_s_fifo.sv
// Synchronous first-word-fall-through FIFO of beats; head is visible while non-empty.
module axis_s_fifo
   import axis_s_rx_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     s_axis_aclk,
   input  logic                     s_axis_areset,
   input  logic                     push,
   input  beat_t                    wr_beat,
   input  logic                     pop,
   output beat_t                    rd_beat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   beat_t           mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);
   // Head is forced to zero when empty so stale storage never leaks out.
   assign rd_beat = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge s_axis_aclk) begin
      if (push)
         mem[wr_ptr] <= wr_beat;
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axis_s_rx.sv
// AXI4-Stream slave receiver: beat FIFO, packet framing FSM and packet statistics.
// Optional per-packet XOR checksum enabled by defining AXIS_S_RX_CSUM_EN.
//
// state | meaning
// IDLE  | waiting for first beat of a packet
// RECV  | inside a packet, beat_cnt beats accepted so far
module axis_s_rx
   import axis_s_rx_pkg::*;
#(
   parameter int DATA_W      = AXIS_DATA_W,
   parameter int DEPTH       = 8,
   parameter int MAX_PKT_LEN = 16
) (
   input  logic                             s_axis_aclk,
   input  logic                             s_axis_areset,
   input  logic [DATA_W-1:0]                s_axis_tdata,
   input  logic                             s_axis_tvalid,
   input  logic                             s_axis_tlast,
   output logic                             s_axis_tready,
   output logic [DATA_W-1:0]                dout,
   output logic                             dout_last,
   output logic                             dout_valid,
   input  logic                             dout_ready,
   output logic                             pkt_done,
   output logic [$clog2(MAX_PKT_LEN):0]     pkt_len,
   output logic                             pkt_err,
   output logic [PKT_CNT_W-1:0]             pkt_cnt,
   output logic [DATA_W-1:0]                pkt_csum
);

   localparam int LEN_W = $clog2(MAX_PKT_LEN) + 1;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MAX_PKT_LEN);
   localparam logic [CW-1:0]    DEPTH_C   = CW'(DEPTH);

   rx_state_e         state;
   logic [LEN_W-1:0]  beat_cnt;
   logic [LEN_W-1:0]  next_len;
   logic              accept;
   logic              force_term;
   logic              finish;
   beat_t             wr_beat;
   beat_t             rd_beat;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CW-1:0]     fifo_count;

   assign s_axis_tready = !s_axis_areset && (fifo_count < DEPTH_C);
   assign accept        = s_axis_tvalid && s_axis_tready;

   // Length the packet would have if the current beat is accepted.
   assign next_len   = (state == RECV) ? beat_cnt + 1'b1 : LEN_W'(1);
   assign force_term = !s_axis_tlast && (next_len == MAX_LEN_C);
   assign finish     = accept && (s_axis_tlast || force_term);

   assign wr_beat.last = s_axis_tlast || force_term;
   assign wr_beat.data = s_axis_tdata;

   assign dout       = rd_beat.data;
   assign dout_last  = rd_beat.last;
   assign dout_valid = !fifo_empty;

   axis_s_fifo #(.DEPTH(DEPTH)) u_fifo (
      .s_axis_aclk   (s_axis_aclk),
      .s_axis_areset (s_axis_areset),
      .push          (accept),
      .wr_beat       (wr_beat),
      .pop           (dout_valid && dout_ready),
      .rd_beat       (rd_beat),
      .full          (fifo_full),
      .empty         (fifo_empty),
      .count         (fifo_count)
   );

   always_ff @(posedge s_axis_aclk) begin
      if (!s_axis_areset)
         assert (!(fifo_full && accept));
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         state    <= IDLE;
         beat_cnt <= '0;
      end else if (accept) begin
         if (finish) begin
            state    <= IDLE;
            beat_cnt <= '0;
         end else begin
            state    <= RECV;
            beat_cnt <= next_len;
         end
      end
   end

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         pkt_done <= 1'b0;
         pkt_len  <= '0;
         pkt_err  <= 1'b0;
         pkt_cnt  <= '0;
      end else begin
         pkt_done <= finish;
         if (finish) begin
            pkt_len <= next_len;
            pkt_err <= force_term;
            pkt_cnt <= pkt_cnt + 1'b1;
         end
      end
   end

`ifdef AXIS_S_RX_CSUM_EN
   logic [DATA_W-1:0] csum_acc;

   always_ff @(posedge s_axis_aclk) begin
      if (s_axis_areset) begin
         csum_acc <= '0;
         pkt_csum <= '0;
      end else if (accept) begin
         if (finish) begin
            csum_acc <= '0;
            pkt_csum <= csum_acc ^ s_axis_tdata;
         end else begin
            csum_acc <= csum_acc ^ s_axis_tdata;
         end
      end
   end
`else
   assign pkt_csum = '0;
`endif

endmodule
